// File: rtl/vga_sync_rx.sv
// -----------------------------------------------------------------------------
// vga_sync_rx
//
// Receive-side companion to a VGA sync generator. Samples the active-low
// H_SYNC / V_SYNC pair in the pixel-clock domain. From them it recovers the
// pixel column, the line and the active-video flag. It also checks line and
// frame timing against the nominal parameters, and declares lock after
// LOCK_FRAMES consecutive clean frames.
//
// Line timing, as seen from the H_SYNC falling edge (pos = 0):
//   pos 0 .. B-1           sync low
//   pos B .. B+C-1         back porch
//   pos HSKIP .. +D-1      active pixels (oCurrent_X = 0 .. D-1)
//   remaining A clocks     front porch
// Frame timing follows the same pattern in lines, starting at the V_SYNC
// falling edge (vline = 0).
//
// Ports
//   CLK          in   pixel clock, single clock domain
//   SYNC_RST_N   in   synchronous active-low reset
//   H_SYNC       in   horizontal sync, active low, synchronous to CLK
//   V_SYNC       in   vertical sync, active low, synchronous to CLK
//   oCurrent_X   out  recovered pixel column (11 bits)
//   oCurrent_Y   out  recovered line (11 bits)
//   oACTIVE      out  inside the active area
//   oLOCKED      out  timing locked
//   oERR         out  one-cycle pulse on any timing violation
//   oH_TOTAL     out  last measured line length in clocks (11 bits)
//   oV_TOTAL     out  last measured frame length in lines (11 bits)
//
// Build option
//   VGA_SYNC_RX_MEAS_EN  when defined, oH_TOTAL / oV_TOTAL capture the
//                        measured line / frame length. When undefined they
//                        are tied to 0 and no capture registers are built.
//                        Lock and checking behaviour is the same either way.
//
// All outputs are registered. X/Y/ACTIVE reflect the sync sample taken on the
// previous clock.
// -----------------------------------------------------------------------------
`default_nettype none

module vga_sync_rx #(
    parameter int A_TIME_H    = 24,
    parameter int B_TIME_H    = 95,
    parameter int C_TIME_H    = 48,
    parameter int D_TIME_H    = 640,
    parameter int A_TIME_V    = 10,
    parameter int B_TIME_V    = 2,
    parameter int C_TIME_V    = 33,
    parameter int D_TIME_V    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        SYNC_RST_N,
    input  logic        H_SYNC,
    input  logic        V_SYNC,
    output logic [10:0] oCurrent_X,
    output logic [10:0] oCurrent_Y,
    output logic        oACTIVE,
    output logic        oLOCKED,
    output logic        oERR,
    output logic [10:0] oH_TOTAL,
    output logic [10:0] oV_TOTAL
);

    // -------------------------------------------------------------------------
    // Derived timing constants
    // -------------------------------------------------------------------------
    localparam int TOTAL_TIME_H = A_TIME_H + B_TIME_H + C_TIME_H + D_TIME_H;
    localparam int TOTAL_TIME_V = A_TIME_V + B_TIME_V + C_TIME_V + D_TIME_V;
    localparam int HSKIP        = B_TIME_H + C_TIME_H;
    localparam int VSKIP        = B_TIME_V + C_TIME_V;
    localparam int GOOD_W       = $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] CNT_MAX     = 11'h7FF;
    localparam logic [10:0] H_TOTAL_C   = 11'(TOTAL_TIME_H);
    localparam logic [10:0] H_SYNC_W    = 11'(B_TIME_H);
    localparam logic [10:0] H_TIMEOUT   = 11'(2 * TOTAL_TIME_H);
    localparam logic [10:0] V_LAST_C    = 11'(TOTAL_TIME_V - 1);
    localparam logic [10:0] H_SKIP_C    = 11'(HSKIP);
    localparam logic [10:0] H_ACT_LAST  = 11'(HSKIP + D_TIME_H - 1);
    localparam logic [10:0] V_SKIP_C    = 11'(VSKIP);
    localparam logic [10:0] V_ACT_LAST  = 11'(VSKIP + D_TIME_V - 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              h_prev;     // H_SYNC delayed one clock
    logic              v_prev;     // V_SYNC as sampled at the previous hfall
    logic [10:0]       hcnt;       // clocks since the last hfall
    logic [10:0]       vline;      // lines since the last vfall
    logic              h_seen;     // at least one hfall since reset
    state_t            state;
    state_t            state_next;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_next;

    // -------------------------------------------------------------------------
    // Edge detection and position
    // -------------------------------------------------------------------------
    logic        hfall;
    logic        hrise;
    logic        vfall;
    logic [10:0] pos;
    logic [10:0] hcnt_inc;
    logic [10:0] vline_inc;

    assign hfall = h_prev & ~H_SYNC;
    assign hrise = ~h_prev & H_SYNC;
    // V_SYNC only matters at line starts, so a frame begins on the first line
    // whose hfall sees V_SYNC low after a line that saw it high.
    assign vfall = hfall & v_prev & ~V_SYNC;
    assign pos   = hfall ? 11'd0 : hcnt;

    assign hcnt_inc  = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 11'd1;
    assign vline_inc = (vline == CNT_MAX) ? CNT_MAX : vline + 11'd1;

    // -------------------------------------------------------------------------
    // Timing checks
    // -------------------------------------------------------------------------
    logic err_hlen;
    logic err_hsync;
    logic err_frame;
    logic timeout;
    logic tracking;
    logic violation;

    // hcnt holds the clocks since the previous hfall, so at the next hfall it
    // equals the full line length.
    assign err_hlen  = hfall & h_seen & (hcnt != H_TOTAL_C);
    assign err_hsync = hrise & h_seen & (pos != H_SYNC_W);
    // Only evaluated outside SEARCH, where the vfall that left SEARCH has
    // already opened the frame being measured.
    assign err_frame = vfall & (vline != V_LAST_C);
    // hcnt passes this value only once before saturating, so a lost H_SYNC
    // raises a single violation rather than one per clock.
    assign timeout   = ~hfall & (hcnt == H_TIMEOUT);
    assign tracking  = (state != ST_SEARCH);
    assign violation = tracking & (err_hlen | err_hsync | err_frame | timeout);

    // -------------------------------------------------------------------------
    // Lock FSM: next-state logic
    // -------------------------------------------------------------------------
    logic [GOOD_W-1:0] good_inc;
    assign good_inc = good_cnt + GOOD_W'(1);

    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        case (state)
            ST_SEARCH: begin
                // A timeout keeps the FSM here; it can never coincide with a
                // vfall, but the guard keeps the intent explicit.
                if (vfall && !timeout) begin
                    state_next = ST_TRACK;
                    good_next  = '0;
                end
            end
            ST_TRACK: begin
                // A violation on the closing vfall wins: that frame is lost.
                if (violation) begin
                    state_next = ST_SEARCH;
                    good_next  = '0;
                end else if (vfall) begin
                    good_next = good_inc;
                    if (good_inc == GOOD_TARGET) begin
                        state_next = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (violation) begin
                    state_next = ST_SEARCH;
                    good_next  = '0;
                end
            end
            default: begin
                state_next = ST_SEARCH;
                good_next  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sync sampling and counters
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) begin
            h_prev <= 1'b1;
            v_prev <= 1'b1;
            hcnt   <= '0;
            vline  <= '0;
            h_seen <= 1'b0;
        end else begin
            h_prev <= H_SYNC;
            if (hfall) begin
                v_prev <= V_SYNC;
                h_seen <= 1'b1;
            end
            hcnt <= hfall ? 11'd1 : hcnt_inc;
            if (vfall) begin
                vline <= '0;
            end else if (hfall) begin
                vline <= vline_inc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Lock FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    logic h_act;
    logic v_act;

    assign h_act = (pos >= H_SKIP_C) && (pos <= H_ACT_LAST);
    assign v_act = (vline >= V_SKIP_C) && (vline <= V_ACT_LAST);

    always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) begin
            oCurrent_X <= '0;
            oCurrent_Y <= '0;
            oACTIVE    <= 1'b0;
            oERR       <= 1'b0;
            oLOCKED    <= 1'b0;
        end else begin
            oCurrent_X <= (pos >= H_SKIP_C) ? pos - H_SKIP_C : 11'd0;
            oCurrent_Y <= (vline >= V_SKIP_C) ? vline - V_SKIP_C : 11'd0;
            oACTIVE    <= h_act & v_act;
            oERR       <= violation;
            // Driven from the next state so lock shows the clock after the
            // qualifying vfall and drops the clock after a violation.
            oLOCKED    <= (state_next == ST_LOCKED);
        end
    end

    // -------------------------------------------------------------------------
    // Optional line / frame length measurement
    // -------------------------------------------------------------------------
`ifdef VGA_SYNC_RX_MEAS_EN
    logic v_seen;  // at least one vfall since reset

    always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) begin
            v_seen   <= 1'b0;
            oH_TOTAL <= '0;
            oV_TOTAL <= '0;
        end else begin
            // The first edge after reset has no complete interval behind it.
            if (hfall && h_seen) begin
                oH_TOTAL <= hcnt;
            end
            if (vfall) begin
                v_seen <= 1'b1;
                if (v_seen) begin
                    oV_TOTAL <= vline_inc;
                end
            end
        end
    end
`else
    assign oH_TOTAL = '0;
    assign oV_TOTAL = '0;
`endif

endmodule

`default_nettype wire

// File: doc/vga_sync_rx.md
# vga_sync_rx

- Receive-side companion to the VGA sync generator.
- Samples active-low H_SYNC/V_SYNC in the pixel-clock domain, recovers pixel X/Y and the active-video flag, and checks line and frame timing against the nominal parameters.
- Declares lock after a run of clean frames.
- Sits in the capture path behind a VGA source, e.g. to drive a frame grabber or a sync-loss monitor.

## Interface
- A_TIME_H, 24, H front porch (clocks)
- B_TIME_H, 95, H sync low width (clocks)
- C_TIME_H, 48, H back porch (clocks)
- D_TIME_H, 640, H active pixels
- A_TIME_V, 10 / B_TIME_V, 2 / C_TIME_V, 33 / D_TIME_V, 480, V equivalents (lines)
- LOCK_FRAMES, 2, consecutive clean frames required for lock
- Derived: TOTAL_TIME_H = A+B+C+D (807); TOTAL_TIME_V (525); HSKIP = B_TIME_H+C_TIME_H; VSKIP = B_TIME_V+C_TIME_V
- CLK  in  1  pixel clock, single clock domain
- SYNC_RST_N  in  1  reset, synchronous, active-low
- H_SYNC  in  1  horizontal sync, active low, synchronous to CLK
- V_SYNC  in  1  vertical sync, active low, synchronous to CLK
- oCurrent_X  out  11  recovered pixel column
- oCurrent_Y  out  11  recovered line
- oACTIVE  out  1  inside active area
- oLOCKED  out  1  timing locked
- oERR  out  1  one-cycle pulse on any timing violation
- oH_TOTAL  out  11  last measured line length (clocks)
- oV_TOTAL  out  11  last measured frame length (lines)

## Operation
- Edge detection:
  - h_prev registers H_SYNC.
  - hfall = h_prev & ~H_SYNC.
  - hrise = ~h_prev & H_SYNC.
- Line position:
  - hcnt <= hfall ? 1 : hcnt+1, saturating at 2047.
  - pos = hfall ? 0 : hcnt.
- Line counting:
  - V_SYNC is sampled only on hfall cycles into v_prev.
  - vfall = hfall & v_prev & ~V_SYNC.
  - vline <= vfall ? 0 : (hfall ? vline+1 : vline), saturating at 2047.
- Recovered outputs, all registered:
  - oCurrent_X = pos-HSKIP if pos ≥ HSKIP, else 0.
  - oCurrent_Y = vline-VSKIP if vline ≥ VSKIP, else 0.
  - oACTIVE = pos in [HSKIP, HSKIP+D_TIME_H-1] and vline in [VSKIP, VSKIP+D_TIME_V-1].
- Line checks (enabled once one hfall has been seen since reset/SEARCH):
  - At hfall: hcnt must equal TOTAL_TIME_H.
  - At hrise: pos must equal B_TIME_H.
- Frame check: at vfall (not the first since SEARCH), vline must equal TOTAL_TIME_V-1.
- Timeout: hcnt reaching 2*TOTAL_TIME_H (1614) without hfall counts as a violation.
- Violation (any check, in TRACK or LOCKED):
  - oERR pulses.
  - State goes to SEARCH.
  - Good-frame count is cleared.
- Lock FSM:
  - SEARCH → TRACK on first vfall; good count = 0.
  - TRACK: each clean frame ending at vfall increments the good count. At LOCK_FRAMES → LOCKED.
  - LOCKED: oLOCKED=1. Stays until a violation.
  - Violations are ignored in SEARCH, except the timeout, which holds the FSM in SEARCH.
- Simultaneous events: violation and vfall in the same cycle → the violation wins; the frame is not counted.
- Reset values: every output 0, state SEARCH, all counters 0, h_prev=1, v_prev=1.

## Timing
- All outputs are registered.
- oCurrent_X/Y and oACTIVE reflect the H_SYNC/V_SYNC sample of the previous cycle (latency 1).
- oERR is high exactly one cycle, the cycle after the violating sample.
- oLOCKED rises the cycle after the LOCK_FRAMES-th clean vfall.
- oLOCKED falls the cycle after a violating sample.
- Reset mid-frame: at the first CLK edge with SYNC_RST_N low, all state returns to reset values. Lock must be re-acquired from SEARCH.

## Configuration
- VGA_SYNC_RX_MEAS_EN defined:
  - oH_TOTAL <= hcnt on every hfall after the first.
  - oV_TOTAL <= vline+1 on every vfall after the first.
  - Both hold between updates.
- Undefined: oH_TOTAL and oV_TOTAL are tied to 0 and the capture registers are not built. Lock and checking behaviour is identical in both cases.

## Test plan
- Default parameters, nominal 807×525 sync stream from reset → oLOCKED rises at the 3rd vfall (2 clean frames), oERR never pulses, oH_TOTAL=807, oV_TOTAL=525.
- Locked, one line stretched to 808 clocks → oERR single pulse at that hfall+1, oLOCKED=0, relock after 2 further clean frames.
- Locked, H_SYNC low width 94 → oERR at hrise+1, state SEARCH.
- Locked, H_SYNC held high → oERR and oLOCKED=0 when hcnt reaches 1614.
- Locked, first active pixel → oACTIVE=1 with oCurrent_X=0, oCurrent_Y=0 one cycle after pos=143, vline=35. Last active pixel → oCurrent_X=639, oCurrent_Y=479.
- SYNC_RST_N low one cycle mid-frame while locked → next cycle all outputs 0; relock after 2 clean frames.
